// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic ops through CALC, WIDTH-step shift-add MUL and
// restoring DIV/MOD through ITER. Define ALU_MULDIV_EN to build the iterative datapath.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             rdy,
  output logic             busy
);

  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_LSR = 5'h03, OP_LSL = 5'h04;
  localparam logic [4:0] OP_RSR = 5'h05, OP_RSL = 5'h06, OP_MOV = 5'h07, OP_MUL = 5'h08;
  localparam logic [4:0] OP_DIV = 5'h09, OP_MOD = 5'h0A, OP_AND = 5'h0B, OP_OR  = 5'h0C;
  localparam logic [4:0] OP_XOR = 5'h0D, OP_NOT = 5'h0E, OP_CMP = 5'h0F, OP_TST = 5'h10;
  localparam logic [4:0] OP_INC = 5'h11, OP_DEC = 5'h12;
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);

  // Handshake: bgn is sampled only in IDLE (busy=0); busy stays high until the edge
  // that raises the one-cycle rdy pulse, so a new bgn may arrive in the rdy cycle.
  typedef enum logic [1:0] {IDLE, CALC, ITER} state_t;
  state_t state;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             go_iter;

  logic             is_sub;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   addsub, shl, shr;
  logic [WIDTH-1:0] rot_k, rotl, rotr;
  logic [WIDTH-1:0] c_acc1, c_acc2;
  logic             c_carry, c_ovf, c_zero, c_neg, c_neg_hi, c_zero_ok, c_upd_acc, c_upd_flg;

  always_comb begin
    is_sub = (op_q == OP_SUB) || (op_q == OP_CMP) || (op_q == OP_DEC);
    y      = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : b_q;
    // For subtraction the extra top bit is the borrow (a < y).
    addsub = is_sub ? ({1'b0, a_q} - {1'b0, y}) : ({1'b0, a_q} + {1'b0, y});
    shl    = {1'b0, a_q} << b_q;
    shr    = {a_q, 1'b0} >> b_q;
    rot_k  = b_q % W_L;
    rotl   = (a_q << rot_k) | (a_q >> (W_L - rot_k));
    rotr   = (a_q >> rot_k) | (a_q << (W_L - rot_k));

    c_acc1    = '0;
    c_acc2    = '0;
    c_carry   = 1'b0;
    c_ovf     = 1'b0;
    c_neg_hi  = 1'b0;
    c_zero_ok = 1'b1;
    c_upd_acc = 1'b1;
    c_upd_flg = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_CMP: begin
        c_acc1  = addsub[MSB:0];
        c_carry = addsub[WIDTH];
        c_ovf   = is_sub ? ((a_q[MSB] != y[MSB]) && (addsub[MSB] != a_q[MSB]))
                         : ((a_q[MSB] == y[MSB]) && (addsub[MSB] != a_q[MSB]));
        c_upd_acc = (op_q != OP_CMP);
      end
      OP_LSL: begin c_acc1 = shl[MSB:0]; c_carry = shl[WIDTH]; end
      OP_LSR: begin c_acc1 = shr[WIDTH:1]; c_carry = shr[0]; end
      OP_RSL: c_acc1 = rotl;
      OP_RSR: c_acc1 = rotr;
      OP_MOV: c_acc1 = a_q;
      OP_NOT: c_acc1 = ~a_q;
      OP_AND: c_acc1 = a_q & b_q;
      OP_OR:  c_acc1 = a_q | b_q;
      OP_XOR: c_acc1 = a_q ^ b_q;
      OP_TST: begin c_acc1 = a_q & b_q; c_upd_acc = 1'b0; end
`ifdef ALU_MULDIV_EN
      OP_MUL: c_neg_hi = 1'b1;          // only reached with b=0: product is zero
      OP_DIV, OP_MOD: begin c_acc1 = '1; c_acc2 = a_q; c_ovf = 1'b1; end
`else
      OP_MUL, OP_DIV, OP_MOD: begin c_ovf = 1'b1; c_zero_ok = 1'b0; end
`endif
      default: begin c_upd_acc = 1'b0; c_upd_flg = 1'b0; end
    endcase
    c_zero = c_zero_ok && ({c_acc2, c_acc1} == '0);
    c_neg  = c_neg_hi ? c_acc2[MSB] : c_acc1[MSB];
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_diff, f1, f2;
  logic             div_ge, f_zero, f_neg;

  assign go_iter = ((opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD)) && (b != '0);

  // MUL keeps {hi,lo} as partial product : multiplier; DIV keeps remainder : dividend/quotient.
  always_comb begin
    mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? a_q : '0)};
    div_sh   = {hi, lo[MSB]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh[MSB:0] - b_q;
    f1       = (op_q == OP_MOD) ? hi : lo;
    f2       = (op_q == OP_MOD) ? '0 : hi;
    f_zero   = ({f2, f1} == '0);
    f_neg    = (op_q == OP_MUL) ? f2[MSB] : f1[MSB];
  end
`else
  assign go_iter = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc1     <= '0;
      acc2     <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (bgn) begin
            op_q  <= opcode;
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= go_iter ? ITER : CALC;
`ifdef ALU_MULDIV_EN
            hi  <= '0;
            lo  <= (opcode == OP_MUL) ? b : a;
            cnt <= '0;
`endif
          end
        end
        CALC: begin
          if (c_upd_acc) begin
            acc1 <= c_acc1;
            acc2 <= c_acc2;
          end
          if (c_upd_flg) begin
            zero     <= c_zero;
            negative <= c_neg;
            carry    <= c_carry;
            overflow <= c_ovf;
          end
          rdy   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ITER: begin
`ifdef ALU_MULDIV_EN
          if (cnt == CNT_END) begin
            acc1     <= f1;
            acc2     <= f2;
            zero     <= f_zero;
            negative <= f_neg;
            carry    <= 1'b0;
            overflow <= 1'b0;
            rdy      <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (op_q == OP_MUL) begin
              hi <= mul_sum[WIDTH:1];
              lo <= {mul_sum[0], lo[MSB:1]};
            end else begin
              hi <= div_ge ? div_diff : div_sh[MSB:0];
              lo <= {lo[MSB-1:0], div_ge};
            end
          end
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
